// File: rtl/uart_led_cmd.sv
// UART command parser: "Lhh<CR>" sets the LED register, "?<CR>" reads it back.
// Every command ends in a 4-byte reply; rejected commands bump a saturating error counter.
module uart_led_cmd #(
  parameter logic [5:0] LED_INIT = 6'b111110
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_valid,
  output logic       o_rx_data_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_data_valid,
  input  logic       i_tx_data_ready,
  output logic [5:0] o_led,
  output logic [7:0] o_err_cnt
);

  localparam logic [7:0]  ChCr  = 8'h0D;
  localparam logic [7:0]  ChLf  = 8'h0A;
  localparam logic [7:0]  ChL   = 8'h4C;
  localparam logic [7:0]  ChQry = 8'h3F;
  localparam logic [31:0] RspOk = 32'h4F4B0D0A;
  localparam logic [31:0] RspEr = 32'h45520D0A;

  typedef enum logic [2:0] {
    StIdle,
    StHexHi,
    StHexLo,
    StWaitCr,
    StQryCr,
    StDiscard,
    StResp
  } state_e;

  state_e      r_state;
  logic [7:0]  r_value;
  logic [5:0]  r_led;
  logic [7:0]  r_err_cnt;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [23:0] r_pend;
  logic [1:0]  r_idx;

  state_e      w_state_nxt;
  logic [7:0]  w_value_nxt;
  logic [5:0]  w_led_nxt;
  logic [7:0]  w_err_nxt;
  logic [7:0]  w_tx_data_nxt;
  logic        w_tx_valid_nxt;
  logic [23:0] w_pend_nxt;
  logic [1:0]  w_idx_nxt;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_is_cr;
  logic        w_is_hex;
  logic [3:0]  w_nibble;
  logic        w_start;
  logic        w_is_err;
  logic [31:0] w_rsp;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign o_rx_data_ready = (r_state != StResp);
  assign o_tx_data       = r_tx_data;
  assign o_tx_data_valid = r_tx_valid;
  assign o_led           = r_led;
  assign o_err_cnt       = r_err_cnt;

  assign w_rx_fire = i_rx_data_valid && o_rx_data_ready;
  assign w_tx_fire = r_tx_valid && i_tx_data_ready;
  assign w_is_cr   = (i_rx_data == ChCr);

  // 'A'-'F' and 'a'-'f' share low bits 1..6, so +9 maps both to 10..15.
  always_comb begin
    w_is_hex = 1'b1;
    w_nibble = 4'h0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      w_nibble = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
      w_nibble = i_rx_data[3:0] + 4'd9;
    end else begin
      w_is_hex = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_value_nxt    = r_value;
    w_led_nxt      = r_led;
    w_err_nxt      = r_err_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_pend_nxt     = r_pend;
    w_idx_nxt      = r_idx;
    w_start        = 1'b0;
    w_is_err       = 1'b0;
    w_rsp          = RspEr;

    unique case (r_state)
      StIdle: begin
        if (w_rx_fire) begin
          if (i_rx_data == ChL)                   w_state_nxt = StHexHi;
          else if (i_rx_data == ChQry)            w_state_nxt = StQryCr;
          else if (w_is_cr || i_rx_data == ChLf)  w_state_nxt = StIdle;
          else                                    w_state_nxt = StDiscard;
        end
      end
      StHexHi: begin
        if (w_rx_fire) begin
          if (w_is_hex) begin
            w_value_nxt = {w_nibble, r_value[3:0]};
            w_state_nxt = StHexLo;
          end else if (w_is_cr) begin
            w_start  = 1'b1;
            w_is_err = 1'b1;
          end else begin
            w_state_nxt = StDiscard;
          end
        end
      end
      StHexLo: begin
        if (w_rx_fire) begin
          if (w_is_hex) begin
            w_value_nxt = {r_value[7:4], w_nibble};
            w_state_nxt = StWaitCr;
          end else if (w_is_cr) begin
            w_start  = 1'b1;
            w_is_err = 1'b1;
          end else begin
            w_state_nxt = StDiscard;
          end
        end
      end
      StWaitCr: begin
        if (w_rx_fire) begin
          if (w_is_cr) begin
            w_start = 1'b1;
            if (r_value <= 8'h3F) begin
              w_led_nxt = r_value[5:0];
              w_rsp     = RspOk;
            end else begin
              w_is_err = 1'b1;
            end
          end else begin
            w_state_nxt = StDiscard;
          end
        end
      end
      StQryCr: begin
        if (w_rx_fire) begin
          if (w_is_cr) begin
            w_start = 1'b1;
            w_rsp   = {hex_ascii({2'b00, r_led[5:4]}), hex_ascii(r_led[3:0]), ChCr, ChLf};
          end else begin
            w_state_nxt = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (w_rx_fire && w_is_cr) begin
          w_start  = 1'b1;
          w_is_err = 1'b1;
        end
      end
      StResp: begin
        if (w_tx_fire) begin
          if (r_idx == 2'd3) begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = StIdle;
          end else begin
            w_tx_data_nxt = r_pend[23:16];
            w_pend_nxt    = {r_pend[15:0], 8'h00};
            w_idx_nxt     = r_idx + 2'd1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // First reply byte goes out straight from the register loaded with the CR.
    if (w_start) begin
      w_state_nxt    = StResp;
      w_tx_valid_nxt = 1'b1;
      w_tx_data_nxt  = w_rsp[31:24];
      w_pend_nxt     = w_rsp[23:0];
      w_idx_nxt      = 2'd0;
      if (w_is_err && r_err_cnt != 8'hFF) w_err_nxt = r_err_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state    <= StIdle;
      r_value    <= 8'h00;
      r_led      <= LED_INIT;
      r_err_cnt  <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_pend     <= 24'h000000;
      r_idx      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_value    <= w_value_nxt;
      r_led      <= w_led_nxt;
      r_err_cnt  <= w_err_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_pend     <= w_pend_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_led_cmd.sv
// Directed bench for uart_led_cmd: command/reply sequences, back-pressure,
// mid-reply reset and error-counter saturation.
module tb_uart_led_cmd;

  localparam logic [31:0] RspOk = 32'h4F4B0D0A;
  localparam logic [31:0] RspEr = 32'h45520D0A;
  localparam logic [7:0]  Cr    = 8'h0D;
  localparam logic [7:0]  Lf    = 8'h0A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [5:0] led;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  uart_led_cmd #(.LED_INIT(6'b111110)) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_rx_data       (rx_data),
    .i_rx_data_valid (rx_valid),
    .o_rx_data_ready (rx_ready),
    .o_tx_data       (tx_data),
    .o_tx_data_valid (tx_valid),
    .i_tx_data_ready (tx_ready),
    .o_led           (led),
    .o_err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!rx_ready) check_eq("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(Cr);
  endtask

  task automatic expect_reply(input string tag, input logic [31:0] exp);
    logic [31:0] got = 32'h0;
    int waitc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      waitc = 0;
      while (!tx_valid && waitc < 50) begin
        @(negedge clk);
        waitc++;
      end
      if (i == 0) check_eq({tag, "_lat"}, waitc, 32'd0);
      if (!tx_valid) begin
        check_eq({tag, "_timeout"}, {31'd0, tx_valid}, 32'd1);
        break;
      end
      got = {got[23:0], tx_data};
      @(posedge clk);
    end
    @(negedge clk);
    check_eq({tag, "_data"}, got, exp);
    check_eq({tag, "_end"}, {30'd0, tx_valid, rx_ready}, 32'd1);
  endtask

  task automatic expect_silence(input string tag);
    logic seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= tx_valid;
    end
    check_eq(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_led", {26'd0, led}, 32'h3E);
    check_eq("rst_err", {24'd0, err_cnt}, 32'd0);
    check_eq("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Out-of-range value: rejected, LED untouched.
    send_line("L7f");
    check_eq("l7f_led", {26'd0, led}, 32'h3E);
    expect_reply("l7f", RspEr);
    check_eq("l7f_err", {24'd0, err_cnt}, 32'd1);

    send_line("L2A");
    check_eq("l2a_led", {26'd0, led}, 32'h2A);
    expect_reply("l2a", RspOk);
    check_eq("l2a_err", {24'd0, err_cnt}, 32'd1);

    send_line("L05");
    expect_reply("l05", RspOk);
    send_line("?");
    expect_reply("q05", 32'h30350D0A);

    send_line("LZ9");
    expect_reply("lz9", RspEr);
    check_eq("lz9_err", {24'd0, err_cnt}, 32'd2);
    send_line("Lx");
    expect_reply("lx", RspEr);
    check_eq("lx_err", {24'd0, err_cnt}, 32'd3);
    check_eq("lx_led", {26'd0, led}, 32'h05);

    send_byte(Cr);
    send_byte(Lf);
    expect_silence("crlf_noreply");
    check_eq("crlf_err", {24'd0, err_cnt}, 32'd3);

    // Back-pressure: first byte must hold and rx must stay blocked.
    tx_ready = 1'b0;
    send_line("?");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("stall_hold", {22'd0, tx_valid, rx_ready, tx_data}, {22'd0, 1'b1, 1'b0, 8'h30});
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    expect_reply("stall_q", 32'h30350D0A);

    send_line("L40");
    expect_reply("l40", RspEr);
    check_eq("l40_led", {26'd0, led}, 32'h05);
    check_eq("l40_err", {24'd0, err_cnt}, 32'd4);
    send_line("L3F");
    check_eq("l3f_led", {26'd0, led}, 32'h3F);
    expect_reply("l3f", RspOk);
    send_line("?");
    expect_reply("q3f", 32'h33460D0A);
    send_line("L3c");
    expect_reply("l3c", RspOk);
    send_line("?");
    expect_reply("q3c", 32'h33430D0A);

    // LF outside IDLE derails the command; inside DISCARD it is ignored.
    send_byte(8'h4C);
    send_byte(8'h31);
    send_byte(Lf);
    send_byte(8'h32);
    send_byte(Cr);
    expect_reply("lf_hexlo", RspEr);
    send_byte(8'h51);
    send_byte(Lf);
    send_byte(Cr);
    expect_reply("lf_discard", RspEr);
    check_eq("lf_err", {24'd0, err_cnt}, 32'd6);
    check_eq("lf_led", {26'd0, led}, 32'h3C);

    // Reset after two reply bytes have gone out.
    send_line("?");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("rst_mid_valid", {31'd0, tx_valid}, 32'd1);
      @(posedge clk);
    end
    #1;
    tx_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_mid_led", {26'd0, led}, 32'h3E);
    check_eq("rst_mid_err", {24'd0, err_cnt}, 32'd0);
    rst      = 1'b0;
    tx_ready = 1'b1;
    expect_silence("rst_mid_silent");
    check_eq("rst_mid_rx_ready", {31'd0, rx_ready}, 32'd1);
    send_line("L01");
    check_eq("post_rst_led", {26'd0, led}, 32'h01);
    expect_reply("post_rst", RspOk);

    // Error counter saturation.
    for (int k = 0; k < 255; k++) begin
      send_line("X");
      expect_reply("sat", RspEr);
    end
    check_eq("sat_255", {24'd0, err_cnt}, 32'd255);
    send_line("X");
    expect_reply("sat_over", RspEr);
    check_eq("sat_hold", {24'd0, err_cnt}, 32'd255);
    check_eq("sat_led", {26'd0, led}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_led_cmd.md
UART_LED_CMD -- requirements
Module: uart_led_cmd

Interface
REQ-001 Parameter: LED_INIT, default 6'b111110, LED value loaded on reset.
REQ-002 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-003 sys_rst  in  1  reset, synchronous and active-high.
REQ-004 rx_data  in  8  received byte from UART receiver.
REQ-005 rx_data_valid  in  1  rx_data holds a byte.
REQ-006 rx_data_ready  out  1  block can accept a byte.
REQ-007 tx_data  out  8  reply byte to UART transmitter.
REQ-008 tx_data_valid  out  1  tx_data holds a byte to send.
REQ-009 tx_data_ready  in  1  transmitter accepts tx_data this cycle.
REQ-010 led  out  6  LED drive value set by command.
REQ-011 err_cnt  out  8  count of rejected commands, saturating.

Function
REQ-012 The rx transfer SHALL occur only on a cycle where rx_data_valid and rx_data_ready are both 1; the tx transfer SHALL occur only on a cycle where tx_data_valid and tx_data_ready are both 1.
REQ-013 Commands: "Lhh<CR>" sets led, where hh is two hex digits (0-9, A-F, a-f). "?<CR>" queries led. CR = 0x0D.
REQ-014 States: IDLE, HEX_HI, HEX_LO, WAIT_CR, QRY_CR, DISCARD, RESP.
REQ-015 IDLE: 'L' -> HEX_HI; '?' -> QRY_CR; CR or LF (0x0A) -> stay, no reply; any other byte -> DISCARD.
REQ-016 HEX_HI / HEX_LO: hex digit -> latch nibble into an 8-bit value, then advance to HEX_LO / WAIT_CR; CR -> RESP with error reply; any other byte -> DISCARD.
REQ-017 WAIT_CR: CR with value <= 0x3F -> led <= value[5:0] and "OK"; CR with value > 0x3F -> error reply with led unchanged; any other byte -> DISCARD.
REQ-018 QRY_CR: CR -> reply with two uppercase ASCII hex digits of {2'b00,led}; any other byte -> DISCARD.
REQ-019 DISCARD: ignore bytes until CR, then error reply.
REQ-020 Every reply SHALL be exactly 4 bytes: "OK\r\n", "ER\r\n" (0x45 0x52 0x0D 0x0A), or "hh\r\n".
REQ-021 Each error reply SHALL increment err_cnt by 1, saturating at 255.
REQ-022 rx_data_ready SHALL be 1 in every state except RESP, and 0 in RESP.
REQ-023 Latency: when the terminating CR is accepted in cycle N, the block SHALL update led (if applicable), enter RESP, and drive tx_data_valid=1 with the first reply byte in cycle N+1.
REQ-024 In RESP, tx_data SHALL hold stable while tx_data_valid=1 and tx_data_ready=0.
REQ-025 After each tx transfer, the next reply byte SHALL be presented in the following cycle, with tx_data_valid held at 1.
REQ-026 After the 4th tx transfer, the block SHALL set tx_data_valid to 0 and return to IDLE in the following cycle.
REQ-027 The query reply SHALL reflect led at the time CR is accepted.
REQ-028 LF received outside IDLE SHALL be treated as an ordinary non-matching byte (-> DISCARD), except in DISCARD, where it is ignored.

Reset
REQ-029 While sys_rst=1 at a clock edge, the block SHALL load: state=IDLE, led=LED_INIT, err_cnt=0, tx_data=0, tx_data_valid=0, value=0.
REQ-030 While sys_rst=1 at a clock edge, rx_data_ready SHALL be 1 from the following cycle.
REQ-031 Reset asserted mid-command or mid-reply SHALL abandon the command or reply without emitting further bytes, and with no change to led beyond LED_INIT.

Verification
REQ-032 "L2A\r", tx_data_ready=1 -> led=6'h2A in the cycle after CR; tx sequence 0x4F 0x4B 0x0D 0x0A; err_cnt=0.
REQ-033 "L7f\r" -> led unchanged (LED_INIT); tx "ER\r\n"; err_cnt=1.
REQ-034 After "L05\r", send "?\r" -> tx "05\r\n" (0x30 0x35 0x0D 0x0A).
REQ-035 "LZ9\r", then "Lx\r" -> two "ER\r\n" replies and err_cnt=2; led unchanged throughout; "\r\n" alone -> no reply.
REQ-036 During a reply, tx_data_ready=0 for 5 cycles -> tx_data/tx_data_valid stable and rx_data_ready=0 throughout; reply completes after tx_data_ready returns to 1.
REQ-037 Assert sys_rst after the 2nd reply byte is transferred -> tx_data_valid=0 next cycle; no further tx bytes; led=LED_INIT; "L01\r" afterwards -> "OK\r\n".
